// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALU-op
// encodings, FSM states and datapath mux-select encodings.
package mips_pkg;

    localparam logic [5:0] OP_RR    = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUctrl_ADD  = 2'b00;
    localparam logic [1:0] ALUctrl_SUB  = 2'b01;
    localparam logic [1:0] ALUctrl_ADDU = 2'b10;
    localparam logic [1:0] ALUctrl_RR   = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_IMMEXEC,
        S_IMMWB,
        S_JUMP
    } state_t;

    typedef enum logic [1:0] {
        SRCB_REGB  = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_IMMSH = 2'b11
    } alusrcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multcyc_ctrl_fsm.sv
// Main control FSM for the shared multicycle MIPS datapath. Sequences each
// instruction and aborts memory states that wait longer than MEM_TIMEOUT.
module multcyc_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       mem_wr,
    output logic       reg_we,
    output logic       wreg_dst_sel,
    output logic       wrbck_sel,
    output logic       illegal_op,
    output logic       bus_err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] tmo_cnt;
    logic [5:0]    op_q;
    logic          mem_st;
    logic          timeout;
    logic          op_legal;
    alusrcb_t      srcb;
    pcsrc_t        pcs;

    assign mem_st   = is_mem_state(state);
    // mem_ready wins over an expiring counter in the same cycle.
    assign timeout  = mem_st && !mem_ready && (tmo_cnt == CW'(MEM_TIMEOUT - 1));
    assign op_legal = opcode inside {OP_RR, OP_J, OP_BEQ, OP_ADDI, OP_ADDIU, OP_LW, OP_SW};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            tmo_cnt <= '0;
            // NOTE: op_q is reset only to keep the IMMEXEC aluop defined after
            // reset; it is reloaded in every DECODE before any use.
            op_q    <= '0;
        end else begin
            state <= state_nx;
            // A timeout in FETCH loops back to FETCH, so it must clear explicitly.
            if (state_nx != state || mem_ready || timeout) begin
                tmo_cnt <= '0;
            end else if (mem_st) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx; no latch inferred.
        state_nx = state;
        unique case (state)
            S_FETCH:   if (mem_ready) state_nx = S_DECODE;
                       else if (timeout) state_nx = S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_nx = S_MEMADR;
                else if (opcode == OP_RR)               state_nx = S_EXEC;
                else if (opcode == OP_BEQ)              state_nx = S_BRANCH;
                else if (opcode == OP_ADDI || opcode == OP_ADDIU) state_nx = S_IMMEXEC;
                else if (opcode == OP_J)                state_nx = S_JUMP;
                else                                    state_nx = S_FETCH;
            end
            S_MEMADR:  state_nx = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_nx = S_MEMWB;
                       else if (timeout) state_nx = S_FETCH;
            S_MEMWR:   if (mem_ready || timeout) state_nx = S_FETCH;
            S_EXEC:    state_nx = S_ALUWB;
            S_IMMEXEC: state_nx = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: state_nx = S_FETCH;
            default:   state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        iord         = 1'b0;
        irwrite      = 1'b0;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        alusrca      = 1'b0;
        srcb         = SRCB_REGB;
        pcs          = PCSRC_ALU;
        aluop        = ALUctrl_ADD;
        mem_wr       = 1'b0;
        reg_we       = 1'b0;
        wreg_dst_sel = 1'b0;
        wrbck_sel    = 1'b0;
        illegal_op   = 1'b0;
        bus_err      = timeout;
        unique case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                srcb    = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                srcb       = SRCB_IMMSH;
                illegal_op = !op_legal;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                srcb    = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_we    = 1'b1;
                wrbck_sel = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                iord    = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUctrl_RR;
            end
            S_ALUWB: begin
                reg_we       = 1'b1;
                wreg_dst_sel = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUctrl_SUB;
                pcs     = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_IMMEXEC: begin
                alusrca = 1'b1;
                srcb    = SRCB_IMM;
                aluop   = (op_q == OP_ADDIU) ? ALUctrl_ADDU : ALUctrl_ADD;
            end
            S_IMMWB:   reg_we = 1'b1;
            S_JUMP: begin
                pcs     = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        alusrcb = srcb;
        pcsrc   = pcs;
    end

endmodule

// File: tb/tb_multcyc_ctrl_fsm.sv
// Directed bench for multcyc_ctrl_fsm: checks the full output vector every
// cycle against hand-built per-state constants.
module tb_multcyc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, iord, irwrite, pcwrite, branch, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       mem_wr, reg_we, wreg_dst_sel, wrbck_sel, illegal_op, bus_err;

    int n_vec = 0;
    int n_miscmp = 0;

    multcyc_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
        .branch(branch), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .aluop(aluop), .mem_wr(mem_wr), .reg_we(reg_we),
        .wreg_dst_sel(wreg_dst_sel), .wrbck_sel(wrbck_sel),
        .illegal_op(illegal_op), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [17:0] outs;
    assign outs = {mem_req, iord, irwrite, pcwrite, branch, alusrca, alusrcb, pcsrc,
                   aluop, mem_wr, reg_we, wreg_dst_sel, wrbck_sel, illegal_op, bus_err};

    // Field order: req iord irw pcw br srca | srcb | pcsrc | aluop | memwr regwe dst wb ill berr
    localparam logic [17:0] E_FETCH_RDY  = {6'b101100, 2'b01, 2'b00, 2'b00, 6'b000000};
    localparam logic [17:0] E_FETCH_WAIT = {6'b100000, 2'b01, 2'b00, 2'b00, 6'b000000};
    localparam logic [17:0] E_FETCH_TO   = {6'b100000, 2'b01, 2'b00, 2'b00, 6'b000001};
    localparam logic [17:0] E_DECODE     = {6'b000000, 2'b11, 2'b00, 2'b00, 6'b000000};
    localparam logic [17:0] E_DECODE_ILL = {6'b000000, 2'b11, 2'b00, 2'b00, 6'b000010};
    localparam logic [17:0] E_MEMADR     = {6'b000001, 2'b10, 2'b00, 2'b00, 6'b000000};
    localparam logic [17:0] E_MEMRD      = {6'b110000, 2'b00, 2'b00, 2'b00, 6'b000000};
    localparam logic [17:0] E_MEMRD_TO   = {6'b110000, 2'b00, 2'b00, 2'b00, 6'b000001};
    localparam logic [17:0] E_MEMWB      = {6'b000000, 2'b00, 2'b00, 2'b00, 6'b010100};
    localparam logic [17:0] E_MEMWR      = {6'b110000, 2'b00, 2'b00, 2'b00, 6'b100000};
    localparam logic [17:0] E_EXEC       = {6'b000001, 2'b00, 2'b00, 2'b11, 6'b000000};
    localparam logic [17:0] E_ALUWB      = {6'b000000, 2'b00, 2'b00, 2'b00, 6'b011000};
    localparam logic [17:0] E_BRANCH     = {6'b000011, 2'b00, 2'b01, 2'b01, 6'b000000};
    localparam logic [17:0] E_IMMEXEC_S  = {6'b000001, 2'b10, 2'b00, 2'b00, 6'b000000};
    localparam logic [17:0] E_IMMEXEC_U  = {6'b000001, 2'b10, 2'b00, 2'b10, 6'b000000};
    localparam logic [17:0] E_IMMWB      = {6'b000000, 2'b00, 2'b00, 2'b00, 6'b010000};
    localparam logic [17:0] E_JUMP       = {6'b000100, 2'b00, 2'b10, 2'b00, 6'b000000};

    localparam logic [5:0] RR = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, ADDIU = 6'b001001, ANDI = 6'b001100;

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs just after the edge, compare mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic [5:0] op, input logic rdy,
                        input logic [17:0] exp);
        opcode    = op;
        mem_ready = rdy;
        #1;
        check(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = RR; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, then reset landing in the middle of a stalled LW read
        step("reset_fetch",   RR,   1'b0, E_FETCH_WAIT);
        step("lw0_fetch",     RR,   1'b1, E_FETCH_RDY);
        step("lw0_decode",    LW,   1'b1, E_DECODE);
        step("lw0_memadr",    RR,   1'b1, E_MEMADR);
        step("lw0_memrd_w",   RR,   1'b0, E_MEMRD);
        reset = 1'b1;
        step("lw0_memrd_rst", RR,   1'b0, E_MEMRD);
        reset = 1'b0;
        step("rst_to_fetch",  RR,   1'b0, E_FETCH_WAIT);

        // LW with memory always ready: 5 cycles
        step("lw_fetch",      RR,   1'b1, E_FETCH_RDY);
        step("lw_decode",     LW,   1'b1, E_DECODE);
        step("lw_memadr",     SW,   1'b1, E_MEMADR);
        step("lw_memrd",      SW,   1'b1, E_MEMRD);
        step("lw_memwb",      SW,   1'b1, E_MEMWB);

        // SW with three stalled MEMWR cycles (below the timeout of 4)
        step("sw_fetch",      RR,   1'b1, E_FETCH_RDY);
        step("sw_decode",     SW,   1'b1, E_DECODE);
        step("sw_memadr",     LW,   1'b1, E_MEMADR);
        step("sw_memwr_w1",   LW,   1'b0, E_MEMWR);
        step("sw_memwr_w2",   LW,   1'b0, E_MEMWR);
        step("sw_memwr_w3",   LW,   1'b0, E_MEMWR);
        step("sw_memwr_ack",  LW,   1'b1, E_MEMWR);

        // RR, ADDIU, ADDI (opcode changed after DECODE to prove it was latched)
        step("rr_fetch",      RR,   1'b1, E_FETCH_RDY);
        step("rr_decode",     RR,   1'b1, E_DECODE);
        step("rr_exec",       LW,   1'b1, E_EXEC);
        step("rr_aluwb",      LW,   1'b1, E_ALUWB);
        step("addiu_fetch",   RR,   1'b1, E_FETCH_RDY);
        step("addiu_decode",  ADDIU, 1'b1, E_DECODE);
        step("addiu_exec",    ADDI, 1'b1, E_IMMEXEC_U);
        step("addiu_wb",      ADDI, 1'b1, E_IMMWB);
        step("addi_fetch",    RR,   1'b1, E_FETCH_RDY);
        step("addi_decode",   ADDI, 1'b1, E_DECODE);
        step("addi_exec",     ADDIU, 1'b1, E_IMMEXEC_S);
        step("addi_wb",       ADDIU, 1'b1, E_IMMWB);

        // BEQ and J: 3 cycles each
        step("beq_fetch",     RR,   1'b1, E_FETCH_RDY);
        step("beq_decode",    BEQ,  1'b1, E_DECODE);
        step("beq_branch",    RR,   1'b1, E_BRANCH);
        step("j_fetch",       RR,   1'b1, E_FETCH_RDY);
        step("j_decode",      JMP,  1'b1, E_DECODE);
        step("j_jump",        RR,   1'b1, E_JUMP);

        // Unsupported opcode: pulse in DECODE, straight back to FETCH
        step("andi_fetch",    RR,   1'b1, E_FETCH_RDY);
        step("andi_decode",   ANDI, 1'b1, E_DECODE_ILL);
        step("andi_refetch",  RR,   1'b1, E_FETCH_RDY);
        step("andi_after",    RR,   1'b1, E_DECODE);
        step("andi_exec",     RR,   1'b1, E_EXEC);
        step("andi_wb",       RR,   1'b1, E_ALUWB);

        // FETCH timeout on the 4th idle cycle, then ack on the 4th cycle wins
        step("to_fetch_w1",   RR,   1'b0, E_FETCH_WAIT);
        step("to_fetch_w2",   RR,   1'b0, E_FETCH_WAIT);
        step("to_fetch_w3",   RR,   1'b0, E_FETCH_WAIT);
        step("to_fetch_err",  RR,   1'b0, E_FETCH_TO);
        step("to_refetch_w1", RR,   1'b0, E_FETCH_WAIT);
        step("to_refetch_w2", RR,   1'b0, E_FETCH_WAIT);
        step("to_refetch_w3", RR,   1'b0, E_FETCH_WAIT);
        step("to_refetch_ack", RR,  1'b1, E_FETCH_RDY);
        step("to_decode",     JMP,  1'b1, E_DECODE);
        step("to_jump",       RR,   1'b1, E_JUMP);

        // MEMRD timeout aborts to FETCH with no writeback
        step("lwto_fetch",    RR,   1'b1, E_FETCH_RDY);
        step("lwto_decode",   LW,   1'b1, E_DECODE);
        step("lwto_memadr",   RR,   1'b1, E_MEMADR);
        step("lwto_w1",       RR,   1'b0, E_MEMRD);
        step("lwto_w2",       RR,   1'b0, E_MEMRD);
        step("lwto_w3",       RR,   1'b0, E_MEMRD);
        step("lwto_err",      RR,   1'b0, E_MEMRD_TO);
        step("lwto_fetch2",   RR,   1'b0, E_FETCH_WAIT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
